// File: rtl/set_reset_flag_bank.sv
// Bank of WIDTH set/reset flags with change pulses, popcount and any-flag summary.
// Optional sticky per-channel overflow flags: define SET_RESET_FLAG_BANK_OVERFLOW_EN.
module set_reset_flag_bank #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               CONFLICT_MODE = 0,
    parameter int               EDGE_SET      = 0
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [WIDTH-1:0]             set,
    input  logic [WIDTH-1:0]             reset,
    input  logic                         clear_all,
    output logic [WIDTH-1:0]             state,
    output logic [WIDTH-1:0]             rise,
    output logic [WIDTH-1:0]             fall,
    output logic                         any,
    output logic [$clog2(WIDTH+1)-1:0]   count
`ifdef SET_RESET_FLAG_BANK_OVERFLOW_EN
    ,
    output logic [WIDTH-1:0]             overflow
`endif
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        SET_WINS   = 2'd0,
        RESET_WINS = 2'd1,
        TOGGLE     = 2'd2,
        HOLD       = 2'd3
    } conflict_e;

    localparam conflict_e POLICY = conflict_e'(CONFLICT_MODE[1:0]);

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    logic [WIDTH-1:0] set_prev;
    logic [WIDTH-1:0] es;
    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] conflict_val;
    logic [WIDTH-1:0] next_state;

    always_comb begin
        es   = (EDGE_SET != 0) ? (set & ~set_prev) : set;
        both = es & reset;
        conflict_val = state;
        case (POLICY)
            SET_WINS:   conflict_val = '1;
            RESET_WINS: conflict_val = '0;
            TOGGLE:     conflict_val = ~state;
            HOLD:       conflict_val = state;
        endcase
        // Per bit: conflict resolution, lone set, lone reset (forces 0), else hold.
        if (clear_all) begin
            next_state = '0;
        end else begin
            next_state = (both & conflict_val) | (es & ~reset) | (~es & ~reset & state);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= RESET_VALUE;
            rise     <= '0;
            fall     <= '0;
            count    <= popcount(RESET_VALUE);
            set_prev <= '0;
        end else begin
            state    <= next_state;
            rise     <= next_state & ~state;
            fall     <= state & ~next_state;
            count    <= popcount(next_state);
            set_prev <= set;
        end
    end

    assign any = |state;

`ifdef SET_RESET_FLAG_BANK_OVERFLOW_EN
    logic [WIDTH-1:0] overflow_next;

    always_comb begin
        if (clear_all) begin
            overflow_next = '0;
        end else begin
            overflow_next = (overflow | (es & state)) & ~reset;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow <= '0;
        end else begin
            overflow <= overflow_next;
        end
    end
`endif

endmodule

// File: tb/tb_set_reset_flag_bank.sv
// Scoreboard bench: four flag banks (one per conflict policy, alternating edge/level set)
// driven by shared directed and random stimulus, checked against a per-channel rule model.
module tb_set_reset_flag_bank;

    localparam int NDUT = 4;
    localparam logic [7:0] RV = 8'hA5;

    logic       clock;
    logic       resetn;
    logic [7:0] set_i;
    logic [7:0] reset_i;
    logic       clr;

    logic [7:0] st_o  [NDUT];
    logic [7:0] ri_o  [NDUT];
    logic [7:0] fa_o  [NDUT];
    logic [7:0] ov_o  [NDUT];
    logic       an_o  [NDUT];
    logic [3:0] cn_o  [NDUT];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        set_reset_flag_bank #(
            .WIDTH        (8),
            .RESET_VALUE  (RV),
            .CONFLICT_MODE(k),
            .EDGE_SET     (k % 2)
        ) u_dut (
            .clock    (clock),
            .resetn   (resetn),
            .set      (set_i),
            .reset    (reset_i),
            .clear_all(clr),
            .state    (st_o[k]),
            .rise     (ri_o[k]),
            .fall     (fa_o[k]),
            .any      (an_o[k]),
            .count    (cn_o[k])
`ifdef SET_RESET_FLAG_BANK_OVERFLOW_EN
            ,
            .overflow (ov_o[k])
`endif
        );
`ifndef SET_RESET_FLAG_BANK_OVERFLOW_EN
        assign ov_o[k] = '0;
`endif
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         dut;
        logic [7:0] st;
        logic [7:0] ri;
        logic [7:0] fa;
        logic [7:0] ov;
        logic [3:0] cn;
        logic       an;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state per bank
    logic [7:0] m_st   [NDUT];
    logic [7:0] m_prev [NDUT];
    logic [7:0] m_ov   [NDUT];

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, d, act, want, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        int d;
        d = e.dut;
        chk("state", d, st_o[d], e.st);
        chk("rise",  d, ri_o[d], e.ri);
        chk("fall",  d, fa_o[d], e.fa);
        chk("count", d, {4'h0, cn_o[d]}, {4'h0, e.cn});
        chk("any",   d, {7'h0, an_o[d]}, {7'h0, e.an});
`ifdef SET_RESET_FLAG_BANK_OVERFLOW_EN
        chk("overflow", d, ov_o[d], e.ov);
`endif
    endtask

    function automatic exp_t reset_exp(input int d);
        exp_t e;
        e.dut = d; e.st = RV; e.ri = '0; e.fa = '0; e.ov = '0;
        e.cn = 4'($countones(RV)); e.an = (RV != 0);
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_st[d] = RV; m_prev[d] = '0; m_ov[d] = '0;
        end
    endtask

    // Apply one clock worth of requests to bank d, following the channel rules directly.
    function automatic exp_t model_step(input int d, input logic [7:0] s, input logic [7:0] r, input logic c);
        exp_t e;
        logic [7:0] ns;
        logic [7:0] nov;
        bit   es;
        for (int i = 0; i < 8; i++) begin
            es = (d % 2 == 1) ? (s[i] && !m_prev[d][i]) : s[i];
            if (c)                 ns[i] = 1'b0;
            else if (es && r[i]) begin
                if (d == 0)        ns[i] = 1'b1;
                else if (d == 1)   ns[i] = 1'b0;
                else if (d == 2)   ns[i] = !m_st[d][i];
                else               ns[i] = m_st[d][i];
            end
            else if (es)           ns[i] = 1'b1;
            else if (r[i])         ns[i] = 1'b0;
            else                   ns[i] = m_st[d][i];
            if (c || r[i])                nov[i] = 1'b0;
            else if (es && m_st[d][i])    nov[i] = 1'b1;
            else                          nov[i] = m_ov[d][i];
        end
        e.dut = d;
        e.st  = ns;
        e.ri  = ns & ~m_st[d];
        e.fa  = m_st[d] & ~ns;
        e.cn  = 4'($countones(ns));
        e.an  = (ns != 0);
        e.ov  = nov;
        m_st[d]   = ns;
        m_ov[d]   = nov;
        m_prev[d] = s;
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the post-edge expectation.
    task automatic step(input logic [7:0] s, input logic [7:0] r, input logic c, input logic rn);
        @(negedge clock);
        set_i = s; reset_i = r; clr = c;
        if (!rn) begin
            if (resetn) begin
                resetn = 1'b0;
                model_reset();
                #1;
                for (int d = 0; d < NDUT; d++) chk_all(reset_exp(d));
            end
            model_reset();
            for (int d = 0; d < NDUT; d++) q.push_back(reset_exp(d));
        end else begin
            resetn = 1'b1;
            for (int d = 0; d < NDUT; d++) q.push_back(model_step(d, s, r, c));
        end
    endtask

    // Monitor: outputs are presented every cycle; compare whatever the driver queued.
    always @(posedge clock) begin
        #1;
        while (q.size() > 0) chk_all(q.pop_front());
    end

    logic [7:0] rs, rr;
    logic       rc, rn;

    initial begin
        resetn = 1'b0; set_i = '0; reset_i = '0; clr = 1'b0;
        model_reset();
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        // Release, idle
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        // Level/edge set of already-set bit, then new bit, then reset bit 7
        step(8'h01, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h02, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h80, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        // Conflict on bit 4 held for four cycles
        for (int n = 0; n < 4; n++) step(8'h10, 8'h10, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        // Set bit 3 held five cycles, reset pulsed mid-hold, then re-arm
        step(8'h00, 8'h08, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) step(8'h08, (n == 2) ? 8'h08 : 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h08, 8'h00, 1'b0, 1'b1);
        // Fill, then clear_all with a colliding set
        step(8'hFF, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h01, 8'h00, 1'b1, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        // Overflow: set bit 0 twice, then reset it, then set twice and reset mid-sequence
        step(8'h01, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h01, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h01, 1'b0, 1'b1);
        step(8'h01, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h01, 8'h00, 1'b0, 1'b1);
        step(8'h01, 8'h00, 1'b0, 1'b0);
        step(8'h01, 8'h00, 1'b0, 1'b1);
        step(8'h01, 8'h00, 1'b0, 1'b1);
        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rs = 8'($urandom) & 8'($urandom);
            rr = 8'($urandom) & 8'($urandom);
            rc = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 49) != 0);
            step(rs, rr, rc, rn);
        end
        step(8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clock);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/set_reset_flag_bank.md
Name: set_reset_flag_bank

Overview:
Bank of WIDTH independent set-reset flags with active-low asynchronous reset and a configurable policy for simultaneous set and reset. Each flag has registered change-event pulses, optional edge-triggered set inputs and a synchronous global clear. A registered popcount and an any-flag summary are provided. Intended for interrupt-pending and status-flag collection in peripherals and controllers.

Parameters:
- WIDTH, 8, number of flag channels (≥1).
- RESET_VALUE, 0, WIDTH-bit value loaded into state on resetn.
- CONFLICT_MODE, 0, action when set and reset are both effective on a channel: 0 = set wins, 1 = reset wins, 2 = toggle, 3 = hold.
- EDGE_SET, 0, when 0 set is level-sensitive; when 1 set is effective only on a 0→1 transition of set[i].

Ports:
- clock  input  1  clock, rising edge.
- resetn  input  1  asynchronous reset, active-low.
- set  input  WIDTH  per-channel set request.
- reset  input  WIDTH  per-channel reset request.
- clear_all  input  1  synchronous clear of every channel.
- state  output  WIDTH  flag values (registered).
- rise  output  WIDTH  one-cycle pulse when state[i] goes 0→1 (registered).
- fall  output  WIDTH  one-cycle pulse when state[i] goes 1→0 (registered).
- any  output  1  OR-reduction of state (combinational from state).
- count  output  $clog2(WIDTH+1)  number of ones in state (registered).

Behaviour:
- Reset (resetn=0, asynchronous): state=RESET_VALUE; rise=0; fall=0; count=popcount(RESET_VALUE); set_previous=0.
- Effective set: es[i] = set[i] when EDGE_SET=0; es[i] = set[i] & ~set_previous[i] when EDGE_SET=1. set_previous is registered every cycle.
  - set_previous resets to 0, so a set held high through reset release produces exactly one effective set, on the first active edge.
- Next state, per channel, priority high→low:
  - clear_all → 0.
  - es & reset → per CONFLICT_MODE (1, 0, ~state, state).
  - es only → 1.
  - reset only → 0.
  - neither → hold.
- Latency: inputs sampled on a rising edge appear on state after that edge, i.e. one cycle.
- rise/fall are registered alongside state and assert in the same cycle the state change becomes visible. Each lasts exactly one cycle per transition.
  - Toggle mode with both inputs held: state alternates every cycle; rise and fall alternate accordingly.
- count is registered from the popcount of next state, so it is always consistent with state in the same cycle. Width $clog2(WIDTH+1) holds values 0..WIDTH without wrap.
- clear_all: state→0; fall pulses for every channel that was 1; no rise pulses; count→0. set_previous still updates, so in edge mode a set held through clear_all does not re-trigger.
- Set on an already-set flag, or reset on an already-clear flag: no change, no pulse.
- Reset asserted mid-operation: all outputs return immediately to reset values; in-flight pulses are discarded.

Optional Feature:
- Macro: SET_RESET_FLAG_BANK_OVERFLOW_EN.
- Defined: adds port overflow, output, WIDTH bits, registered, reset 0.
  - overflow[i] is set when es[i]=1 while state[i]=1 and the channel is not cleared or reset in the same cycle.
  - It is sticky; it is cleared by reset[i] or clear_all (clear takes priority over a simultaneous set of overflow).
- Not defined: no overflow port and no associated logic.

Test Plan:
- WIDTH=8, RESET_VALUE=8'hA5: hold resetn=0 → state=8'hA5, count=4, any=1, rise=fall=0. Release, no inputs → state unchanged.
- Level mode: set=8'h01 for one cycle → next cycle state=8'hA5|01 unchanged; then set=8'h02 → state=8'hA7, rise=8'h02 for one cycle, count=5. Then reset=8'h80 → state=8'h27, fall=8'h80, count=4.
- Conflict: set=reset=8'h10 held 4 cycles, per mode. Mode0 → state[4]=1 constant. Mode1 → 0 constant. Mode2 → toggles each cycle with alternating rise/fall. Mode3 → holds initial value.
- EDGE_SET=1: set[3] held high 5 cycles → exactly one rise[3]. Reset[3] pulsed mid-hold → state[3]=0, no re-set until set[3] drops and rises again.
- clear_all with state=8'hFF → state=0, fall=8'hFF, count=0, any=0 next cycle; same cycle set=8'h01 → ignored.
- OVERFLOW_EN defined: set[0] twice without reset → overflow[0]=1 after the second set. reset[0] → overflow[0]=0. Assert resetn mid-sequence → overflow=0 immediately.
